// File: rtl/seg_pkg.sv
// ---------------------------------------------------------------------------
// seg_pkg
// Shared types and constants for the seven-segment scan controller.
//   scan_state_t : scan FSM states (IDLE, ACTIVE, BLANK)
//   grant_t      : identifies which requester owns the last grant
//   SEG_DIGITS   : number of multiplexed digits
//   SEG_VALUE_W  : width of the displayed value (one nibble per digit)
//   SEG_SEL_W    : width of the digit select
// ---------------------------------------------------------------------------
package seg_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        BLANK  = 2'd2
    } scan_state_t;

    typedef enum logic {
        GRANT_A = 1'b0,
        GRANT_B = 1'b1
    } grant_t;

    localparam int SEG_DIGITS  = 4;
    localparam int SEG_VALUE_W = 16;
    localparam int SEG_SEL_W   = $clog2(SEG_DIGITS);

    // Digit select advances modulo SEG_DIGITS; with a power-of-two digit
    // count the natural register wrap gives the modulo for free.
    function automatic logic [SEG_SEL_W-1:0] next_digit(input logic [SEG_SEL_W-1:0] d);
        return d + 1'b1;
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl_if
// Valid/ready update path from the two writers into the scan controller.
//   a_valid/a_data/a_ready : requester A (processor store path)
//   b_valid/b_data/b_ready : requester B (debug / switch path)
// Modports:
//   master : requester side, drives valid/data, observes ready
//   slave  : controller side, observes valid/data, drives ready
// ---------------------------------------------------------------------------
interface seg_scan_ctrl_if;
    import seg_pkg::*;

    logic                   a_valid;
    logic [SEG_VALUE_W-1:0] a_data;
    logic                   a_ready;
    logic                   b_valid;
    logic [SEG_VALUE_W-1:0] b_data;
    logic                   b_ready;

    modport master (
        output a_valid, a_data, b_valid, b_data,
        input  a_ready, b_ready
    );

    modport slave (
        input  a_valid, a_data, b_valid, b_data,
        output a_ready, b_ready
    );

endinterface

// File: rtl/rr_arbiter2.sv
// ---------------------------------------------------------------------------
// rr_arbiter2
// Two-input round-robin arbiter. The grant is purely combinational from the
// requests and the last_grant register; last_grant only moves when the
// caller reports that a grant was actually consumed (update).
// Ports:
//   clk, rst         : clock, asynchronous active-high reset
//   req_a, req_b     : request lines
//   update           : a handshake happened this cycle, remember the winner
//   grant_a, grant_b : one-hot grant (exactly one is always high)
// ---------------------------------------------------------------------------
module rr_arbiter2
    import seg_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req_a,
    input  logic req_b,
    input  logic update,
    output logic grant_a,
    output logic grant_b
);

    grant_t last_grant;

    // A lone requester always wins. On contention, and also when nobody is
    // asking, the grant parks on whoever did not win last, so the idle
    // grant already points at the requester that is owed the next turn.
    always_comb begin
        grant_a = 1'b0;
        if (req_a && !req_b) begin
            grant_a = 1'b1;
        end else if (req_b && !req_a) begin
            grant_a = 1'b0;
        end else begin
            grant_a = (last_grant == GRANT_B);
        end
        grant_b = ~grant_a;
    end

    // Reset to B so that A wins the very first contention.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= GRANT_B;
        end else if (update) begin
            last_grant <= grant_b ? GRANT_B : GRANT_A;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
// Drives the digit multiplexing of a 4-digit seven-segment display and owns
// the value shown on it. Each digit slot lasts REFRESH_DIV cycles: first an
// active window with anodes on, then BLANK_CYCLES with all anodes off to
// stop ghosting. Two writers update the value through a round-robin
// valid/ready arbiter; accepted data sits in a shadow register and is only
// committed at a frame boundary (digit 3 -> 0) or while idle, so a frame
// never shows a mix of old and new digits.
// Parameters:
//   REFRESH_DIV  : cycles per digit slot (>= 2)
//   BLANK_CYCLES : blanked cycles at the end of each slot (0 disables)
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   enable        : scanning on; low returns to IDLE
//   req           : valid/ready update path from requesters A and B
//   display_value : committed value, nibble n feeds digit n
//   digit_select  : active digit 0..3
//   blank         : high = all anodes off
//   pending       : shadow holds an update not yet committed
// ---------------------------------------------------------------------------
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int REFRESH_DIV  = 100000,
    parameter int BLANK_CYCLES = 1000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    seg_scan_ctrl_if.slave         req,
    output logic [SEG_VALUE_W-1:0] display_value,
    output logic [SEG_SEL_W-1:0]   digit_select,
    output logic                   blank,
    output logic                   pending
);

    localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CNT_W-1:0] SLOT_LAST   = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] ACTIVE_LAST = CNT_W'(REFRESH_DIV - BLANK_CYCLES - 1);
    localparam logic [SEG_SEL_W-1:0] DIGIT_LAST = SEG_SEL_W'(SEG_DIGITS - 1);

    scan_state_t            state;
    scan_state_t            state_next;
    logic [CNT_W-1:0]       slot_cnt;
    logic [CNT_W-1:0]       slot_cnt_next;
    logic [SEG_SEL_W-1:0]   digit_next;
    logic                   frame_wrap;
    logic                   commit;

    logic                   grant_a;
    logic                   grant_b;
    logic                   hs_a;
    logic                   hs_b;
    logic                   handshake;
    logic [SEG_VALUE_W-1:0] accept_data;
    logic [SEG_VALUE_W-1:0] shadow;

    // Scan sequencing. The slot counter runs through the whole slot in both
    // ACTIVE and BLANK; the state only records which part of the slot we
    // are in. The wrap check comes first in ACTIVE so that with no blank
    // interval the slot ends straight into the next ACTIVE slot.
    always_comb begin
        state_next    = state;
        slot_cnt_next = slot_cnt;
        digit_next    = digit_select;
        frame_wrap    = 1'b0;
        if (!enable) begin
            state_next    = IDLE;
            slot_cnt_next = '0;
            digit_next    = '0;
        end else begin
            case (state)
                IDLE: begin
                    state_next    = ACTIVE;
                    slot_cnt_next = '0;
                    digit_next    = '0;
                end
                ACTIVE: begin
                    if (slot_cnt == SLOT_LAST) begin
                        slot_cnt_next = '0;
                        digit_next    = next_digit(digit_select);
                        frame_wrap    = (digit_select == DIGIT_LAST);
                    end else begin
                        slot_cnt_next = slot_cnt + 1'b1;
                        if (slot_cnt == ACTIVE_LAST) begin
                            state_next = BLANK;
                        end
                    end
                end
                BLANK: begin
                    if (slot_cnt == SLOT_LAST) begin
                        state_next    = ACTIVE;
                        slot_cnt_next = '0;
                        digit_next    = next_digit(digit_select);
                        frame_wrap    = (digit_select == DIGIT_LAST);
                    end else begin
                        slot_cnt_next = slot_cnt + 1'b1;
                    end
                end
                default: begin
                    state_next    = IDLE;
                    slot_cnt_next = '0;
                    digit_next    = '0;
                end
            endcase
        end
    end

    // blank is registered from the next state so it moves on exactly the
    // same edge as digit_select; no digit ever sees stale anodes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            slot_cnt     <= '0;
            digit_select <= '0;
            blank        <= 1'b1;
        end else begin
            state        <= state_next;
            slot_cnt     <= slot_cnt_next;
            digit_select <= digit_next;
            blank        <= (state_next != ACTIVE);
        end
    end

    rr_arbiter2 u_arb (
        .clk     (clk),
        .rst     (rst),
        .req_a   (req.a_valid),
        .req_b   (req.b_valid),
        .update  (handshake),
        .grant_a (grant_a),
        .grant_b (grant_b)
    );

    // Only one update can be in flight: while the shadow is occupied both
    // readies stay low, so the loser of a contention simply waits.
    assign req.a_ready = ~pending & grant_a;
    assign req.b_ready = ~pending & grant_b;
    assign hs_a        = req.a_valid & req.a_ready;
    assign hs_b        = req.b_valid & req.b_ready;
    assign handshake   = hs_a | hs_b;
    assign accept_data = hs_a ? req.a_data : req.b_data;

    // Leaving or sitting in IDLE is a safe point to commit because all
    // anodes are off there.
    assign commit = frame_wrap | ~enable | (state == IDLE);

    // A handshake can only occur with pending low, so it never races with
    // clearing a real pending update; setting pending takes priority.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shadow        <= '0;
            pending       <= 1'b0;
            display_value <= '0;
        end else begin
            if (handshake) begin
                shadow  <= accept_data;
                pending <= 1'b1;
            end else if (commit) begin
                pending <= 1'b0;
            end
            if (commit && pending) begin
                display_value <= shadow;
            end
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
# seg_scan_ctrl

- Sequences the 4-digit seven-segment decoder by generating `digit_select` at a programmable refresh rate, with an anti-ghosting blank interval between digits.
- Owns the displayed 16-bit value and shares it between two writers (processor store path A, debug/switch path B) through a round-robin valid/ready arbiter.
- Accepted updates are held in a shadow register and committed only at a frame boundary or while blanked, so the display never tears.
- Sits between the core/debug logic and the seven-segment decoder; the top level forces all anodes off while `blank` is high.

## Interface
- `REFRESH_DIV`, 100000: cycles per digit slot (ACTIVE + BLANK); ≥ 2.
- `BLANK_CYCLES`, 1000: blanked cycles at the end of each slot; 0 ≤ BLANK_CYCLES < REFRESH_DIV; 0 removes BLANK.
- `clk` in 1: system clock; single clock domain.
- `rst` in 1: asynchronous, active-high reset.
- `enable` in 1: scanning on; low forces IDLE.
- `a_valid` in 1, `a_data` in 16, `a_ready` out 1: requester A handshake.
- `b_valid` in 1, `b_data` in 16, `b_ready` out 1: requester B handshake.
- `display_value` out 16: value to decode; nibble n feeds digit n.
- `digit_select` out 2: active digit, 0..3.
- `blank` out 1: high = all anodes off.
- `pending` out 1: shadow holds an uncommitted update.

## Operation
- Reset values: `display_value`=0, `digit_select`=0, `blank`=1, `pending`=0, state IDLE, slot counter 0, last_grant=B (A wins first contention). Readies follow the rule below (A ready, B not).
- States:
  - IDLE: `blank`=1, `digit_select`=0; → ACTIVE on an edge with `enable`=1.
  - ACTIVE: `blank`=0 for REFRESH_DIV−BLANK_CYCLES cycles; → BLANK (or straight to the next slot if BLANK_CYCLES=0).
  - BLANK: `blank`=1 for BLANK_CYCLES cycles; → ACTIVE with `digit_select` incremented mod 4.
  - `enable`=0 in any state → IDLE on the next edge; the slot counter clears.
- Slot counter: width $clog2(REFRESH_DIV); counts 0..REFRESH_DIV−1, then wraps to 0.
- Arbitration (combinational):
  - `x_ready` = ~pending & grant_x.
  - If only one requester is valid, it is granted.
  - If both are valid, the one not equal to last_grant is granted.
  - If neither is valid, the grant defaults to the non-last_grant requester.
  - A handshake is valid&ready; at most one per cycle. On a handshake: shadow ← data, `pending` ← 1, last_grant ← winner.
- Commit: `display_value` ← shadow and `pending` ← 0 on either:
  - the edge where `digit_select` wraps 3→0 (frame boundary), or
  - any edge while in IDLE.
- Simultaneous events:
  - Commit and a new request in the same cycle: the request is not accepted, because ready is low while `pending`=1. It is accepted the cycle after the commit.
  - A and B both valid: only the winner is accepted; the loser keeps `valid` and is accepted after the next commit.
- Requesters must hold `data` stable while valid and not ready.
- Reset mid-operation: all state returns to reset values; the shadow contents and `pending` are discarded.

## Timing
- All outputs except the readies are registered; the readies are combinational from `pending`, the valids and last_grant.
- Handshake → `pending`=1 on the next edge.
- Worst-case handshake → `display_value` latency: 4·REFRESH_DIV cycles (one frame).
- `blank` and `digit_select` change on the same edge, so no digit is ever driven with stale anodes.
- Frame period: 4·REFRESH_DIV cycles. Defaults at 100 MHz give a 1 kHz slot rate and a 250 Hz frame rate.

## Structure
- Shared package `seg_pkg`:
  - state enum `scan_state_t` {IDLE, ACTIVE, BLANK};
  - `SEG_DIGITS`=4;
  - `SEG_VALUE_W`=16.
- Sub-module `rr_arbiter2`: two-input round-robin grant with a last_grant register and update enable.
- Everything else stays flat in `seg_scan_ctrl`.

## Test plan
Unless stated, benches use REFRESH_DIV=8, BLANK_CYCLES=2.
- Reset, then `enable`=1 → `digit_select` sequence 0,1,2,3,0; each digit has `blank`=0 for 6 cycles, then 1 for 2; the period is 32 cycles.
- A writes 0x1234 mid-digit 1 → `a_ready` drops the next cycle and `pending`=1. `display_value` holds 0 until the 3→0 wrap, then reads 0x1234 and `a_ready` returns to 1.
- A=0xAAAA and B=0x5555 valid in the same cycle → A accepted first and committed. B is accepted the cycle after that commit and appears at the following wrap.
- A request arrives in the cycle of the commit edge → not accepted that cycle; accepted the next cycle.
- `enable`=0 with `pending`=1 and shadow 0xBEEF → the next edge gives IDLE, `blank`=1, `digit_select`=0 and `display_value`=0xBEEF.
- `rst` pulsed mid-frame with `pending`=1 → asynchronous return to reset values; the shadow is discarded and `display_value`=0.
- BLANK_CYCLES=0 → `blank` stays 0 while enabled and `digit_select` advances every 8 cycles.
